// File: rtl/puf_ro_pkg.sv
// Shared register map, CTRL field positions and FSM state type for the
// ring-oscillator PUF sampler.
package puf_ro_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RAW    = 2'd2;

  localparam int SEL_A_LSB  = 0;
  localparam int SEL_B_LSB  = 4;
  localparam int WINDOW_LSB = 8;
  localparam int START_BIT  = 31;

  localparam int SETTLE_LEN = 2;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

endpackage

// File: rtl/puf_ro_edge_counter.sv
// One oscillator channel: 2-FF synchroniser, rising-edge detect and a
// saturating edge counter with synchronous clear and count enable.
module puf_ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ro,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // sync[1:0] form the synchroniser, sync[2] holds the previous synced value
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync  <= '0;
      count <= '0;
    end else begin
      sync <= {sync[1:0], ro};
      if (clear) begin
        count <= '0;
      end else if (enable && rise && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/puf_ro_sampler.sv
// Ring-oscillator PUF evaluation peripheral on the PicoSoC iomem bus.
// Define PUF_RO_RAW_READ_EN to expose the raw edge counts at offset 0x8.
module puf_ro_sampler
  import puf_ro_pkg::*;
#(
  parameter int          NUM_RO    = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h05,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [NUM_RO-1:0] ro_in
);

  logic [3:0]       sel_a;
  logic [3:0]       sel_b;
  logic [15:0]      window;
  logic             busy;
  logic             done;
  logic             response;
  logic             tie;
  state_t           state;
  state_t           state_next;
  logic [15:0]      cyc;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [15:0]      ro_pad;
  logic             selected;
  logic             ctrl_wr;
  logic             status_wr;
  logic             start_req;
  logic [31:0]      read_data;
  logic [31:0]      raw_word;
  logic             unused_bits;

  assign selected  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign ctrl_wr   = selected && (iomem_wstrb != 4'd0) && (iomem_addr[3:2] == REG_CTRL) && !busy;
  assign status_wr = selected && iomem_wstrb[0] && (iomem_addr[3:2] == REG_STATUS);
  assign start_req = ctrl_wr && iomem_wstrb[3] && iomem_wdata[START_BIT];

  // Unpopulated channels read as constant 0, so out-of-range selectors count nothing
  assign ro_pad = 16'(ro_in);

  assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[30:24]};

  puf_ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .resetn (resetn),
    .ro     (ro_pad[sel_a]),
    .clear  ((state == IDLE) && busy),
    .enable (state == COUNT),
    .count  (cnt_a)
  );

  puf_ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .resetn (resetn),
    .ro     (ro_pad[sel_b]),
    .clear  ((state == IDLE) && busy),
    .enable (state == COUNT),
    .count  (cnt_b)
  );

`ifdef PUF_RO_RAW_READ_EN
  assign raw_word = {16'(cnt_b), 16'(cnt_a)};
`else
  assign raw_word = 32'd0;
`endif

  // busy in IDLE marks a start accepted on the previous edge
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (busy) state_next = SETTLE;
      SETTLE:  if (cyc == 16'(SETTLE_LEN - 1)) state_next = (window == 16'd0) ? DONE : COUNT;
      COUNT:   if (cyc == window - 16'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_data = 32'd0;
    case (iomem_addr[3:2])
      REG_CTRL:   read_data = {8'd0, window, sel_b, sel_a};
      REG_STATUS: read_data = {28'd0, tie, response, done, busy};
      REG_RAW:    read_data = raw_word;
      default:    read_data = 32'd0;
    endcase
  end

  // DONE is applied last so it overrides a same-cycle W1C of done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cyc         <= 16'd0;
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
      sel_a       <= 4'd0;
      sel_b       <= 4'd0;
      window      <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      response    <= 1'b0;
      tie         <= 1'b0;
    end else begin
      state       <= state_next;
      cyc         <= (state_next != state) ? 16'd0 : cyc + 16'd1;
      iomem_ready <= selected;
      iomem_rdata <= selected ? read_data : 32'd0;

      if (ctrl_wr) begin
        if (iomem_wstrb[0]) begin
          sel_a <= iomem_wdata[SEL_A_LSB +: 4];
          sel_b <= iomem_wdata[SEL_B_LSB +: 4];
        end
        if (iomem_wstrb[1]) window[7:0]  <= iomem_wdata[WINDOW_LSB +: 8];
        if (iomem_wstrb[2]) window[15:8] <= iomem_wdata[WINDOW_LSB + 8 +: 8];
        if (start_req) begin
          busy <= 1'b1;
          done <= 1'b0;
        end
      end

      if (status_wr && iomem_wdata[1]) done <= 1'b0;

      if (state == DONE) begin
        busy     <= 1'b0;
        done     <= 1'b1;
        response <= (cnt_a > cnt_b);
        tie      <= (cnt_a == cnt_b);
      end
    end
  end

endmodule
